dm_sba_slave: RTL
=================

# dm_sba_slave

Bus responder for the debug module's system-bus-access master port. Accepts the req/gnt/r_valid transactions issued by the SBA master (`master_*` ports of the debug top) and replays each one as a single strobe/ready access on the core-side memory port. It sits between the debug top and the memory arbiter. It range-checks addresses, enforces one outstanding access, and returns `r_err` / `r_other_err` so the SBA master can set `sberror`.

## Interface
- `BusWidth`, 32: address and data width; `BusWidth/8` byte enables.
- `AddrBase`, 'h8000_0000: first byte address served.
- `AddrSize`, 'h1000_0000: number of bytes served from `AddrBase`.
- `TimeoutCycles`, 255: memory wait limit in cycles; 0 disables the timeout.

Ports:
- `clk_i`  in  1  single clock.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `req_i`  in  1  request from SBA master (`master_req_o`).
- `add_i`  in  BusWidth  byte address.
- `we_i`  in  1  1 = write.
- `wdata_i`  in  BusWidth  write data.
- `be_i`  in  BusWidth/8  byte enables.
- `gnt_o`  out  1  request accepted.
- `r_valid_o`  out  1  response pulse, issued for reads and writes.
- `r_err_o`  out  1  address or byte-enable error.
- `r_other_err_o`  out  1  memory timeout.
- `r_rdata_o`  out  BusWidth  read data.
- `mem_strobe_o`  out  1  one-cycle access start.
- `mem_addr_o`  out  BusWidth  access address.
- `mem_rw_o`  out  1  1 = write.
- `mem_byte_enable_o`  out  BusWidth/8  byte enables.
- `mem_data_o`  out  BusWidth  write data.
- `mem_ready_i`  in  1  access complete.
- `mem_data_i`  in  BusWidth  read data; valid with `mem_ready_i`.

## Operation
- FSM states: IDLE, MEM, RESP.
- **IDLE**
  - `gnt_o = req_i` (combinational). There is no gnt in MEM or RESP.
  - On a granted edge, the block latches `add_i`, `we_i`, `wdata_i`, `be_i` into the `mem_*` registers.
  - Range check: hit iff `add_i >= AddrBase` and `(add_i - AddrBase) < AddrSize`, computed at BusWidth bits via subtraction. Wrap is impossible even when base+size = 2^BusWidth.
  - Miss, or `be_i == 0`: go to RESP with the `err` flag set. No memory access is made.
  - Otherwise: go to MEM.
- **MEM**
  - `mem_strobe_o` is high in the first MEM cycle only.
  - The wait counter, width clog2(TimeoutCycles+1), clears on entry and increments each MEM cycle without `mem_ready_i`.
  - When `mem_ready_i` is high: capture `mem_data_i` if it is a read (0 if a write), then go to RESP.
  - Timeout: the counter reaches TimeoutCycles-1 with `mem_ready_i` low. Go to RESP with the `other_err` flag set and rdata 0.
  - If `mem_ready_i` arrives in the same cycle as the timeout, `mem_ready_i` wins.
- **RESP**
  - `r_valid_o = 1` for exactly one cycle. `r_err_o` and `r_other_err_o` reflect the flags and are never both 1.
  - The FSM then returns to IDLE and the flags clear.
- `mem_addr_o`, `mem_rw_o`, `mem_byte_enable_o`, `mem_data_o` stay stable from capture until the next capture. The address is forwarded unmodified as a byte address.
- `r_rdata_o` holds its value until the next response. `r_err_o` and `r_other_err_o` are 0 whenever `r_valid_o` is 0.
- `mem_ready_i` is ignored outside MEM. A late ready after a timeout is discarded.
- Asynchronous reset at any point: FSM returns to IDLE, counter clears, and any in-flight access is abandoned with no response.

## Timing
- Reset values: every output is 0. `gnt_o` is 0 while `rst_ni` = 0, independent of `req_i`.
- Cycle numbering: gnt at cycle 0; first MEM cycle and `mem_strobe_o` at cycle 1.
- Memory access: `mem_ready_i` can be sampled from cycle 1 onward. Ready at cycle k gives `r_valid_o` at cycle k+1. Minimum (ready at cycle 1) gives `r_valid_o` at cycle 2.
- Error path: `r_valid_o` at cycle 1.
- Timeout: with no ready, `r_valid_o` with `r_other_err_o` at cycle TimeoutCycles+1.
- Back-to-back: the next gnt is possible the cycle after `r_valid_o`. Minimum repeat interval is 3 cycles for a memory access, 2 for an error.
- The block assumes `req_i` stays high until gnt and that the master accepts `r_valid_o` unconditionally. There is no backpressure.

## Test plan
- Read 'h8000_0010, be 'hF, `mem_ready_i` at cycle 1 with data 'hDEADBEEF -> `gnt_o` at cycle 0, single `mem_strobe_o` at cycle 1 with `mem_rw_o`=0, `r_valid_o` at cycle 2 with rdata 'hDEADBEEF and both errors 0.
- Write 'h8000_0004, wdata 'h12345678, be 'h3, ready after 5 wait cycles -> `mem_*` holds address, data and be 'h3 stable throughout; one `r_valid_o` with rdata 0 and no error.
- Read 'h7FFF_FFFC, write 'h9000_0000, and a request with be 0 -> no `mem_strobe_o`; `r_valid_o` plus `r_err_o` at cycle 1 for each.
- TimeoutCycles=4, no ready -> `r_valid_o` plus `r_other_err_o` at cycle 5. A late `mem_ready_i` at cycle 8 is ignored, and the next request completes normally.
- `req_i` held high over 3 back-to-back reads with immediate ready -> gnts at cycles 0, 3, 6; rdata returned in order.
- Reset asserted during MEM -> all outputs 0 immediately, no `r_valid_o`; the first request after release is granted and completes.

Source files
------------

// File: rtl/dm_sba_slave_if.sv
// rtl/dm_sba_slave_if.sv - SBA request/response and core memory port bundle
interface dm_sba_slave_if #(
  parameter int BusWidth = 32
);
  logic                    req_i;
  logic [BusWidth-1:0]     add_i;
  logic                    we_i;
  logic [BusWidth-1:0]     wdata_i;
  logic [BusWidth/8-1:0]   be_i;
  logic                    gnt_o;
  logic                    r_valid_o;
  logic                    r_err_o;
  logic                    r_other_err_o;
  logic [BusWidth-1:0]     r_rdata_o;
  logic                    mem_strobe_o;
  logic [BusWidth-1:0]     mem_addr_o;
  logic                    mem_rw_o;
  logic [BusWidth/8-1:0]   mem_byte_enable_o;
  logic [BusWidth-1:0]     mem_data_o;
  logic                    mem_ready_i;
  logic [BusWidth-1:0]     mem_data_i;

  modport slave (
    input  req_i, add_i, we_i, wdata_i, be_i, mem_ready_i, mem_data_i,
    output gnt_o, r_valid_o, r_err_o, r_other_err_o, r_rdata_o,
           mem_strobe_o, mem_addr_o, mem_rw_o, mem_byte_enable_o, mem_data_o
  );

  modport master (
    output req_i, add_i, we_i, wdata_i, be_i, mem_ready_i, mem_data_i,
    input  gnt_o, r_valid_o, r_err_o, r_other_err_o, r_rdata_o,
           mem_strobe_o, mem_addr_o, mem_rw_o, mem_byte_enable_o, mem_data_o
  );
endinterface

// File: rtl/dm_sba_slave.sv
// rtl/dm_sba_slave.sv - SBA bus responder replaying each access as one strobe/ready memory cycle
module dm_sba_slave #(
  parameter int                  BusWidth      = 32,
  parameter logic [BusWidth-1:0] AddrBase      = 'h8000_0000,
  parameter logic [BusWidth-1:0] AddrSize      = 'h1000_0000,
  parameter int                  TimeoutCycles = 255
) (
  input logic           clk_i,
  input logic           rst_ni,
  dm_sba_slave_if.slave bus
);

  localparam int CntW = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
  localparam logic [CntW-1:0] CntLast = (TimeoutCycles > 0) ? CntW'(TimeoutCycles - 1) : '0;

  typedef enum logic [1:0] {
    IDLE,
    MEM,
    RESP
  } state_e;

  state_e                state_q, state_d;
  logic [BusWidth-1:0]   addr_q;
  logic                  rw_q;
  logic [BusWidth/8-1:0] be_q;
  logic [BusWidth-1:0]   wdata_q;
  logic [BusWidth-1:0]   rdata_q;
  logic                  strobe_q;
  logic                  err_q;
  logic                  other_err_q;
  logic [CntW-1:0]       cnt_q;

  logic [BusWidth-1:0]   offset;
  logic                  access_ok;
  logic                  timeout;

  // Subtracting first keeps the range check free of base+size overflow.
  assign offset    = bus.add_i - AddrBase;
  assign access_ok = (bus.add_i >= AddrBase) && (offset < AddrSize) && (bus.be_i != '0);
  assign timeout   = (TimeoutCycles > 0) && (cnt_q == CntLast) && !bus.mem_ready_i;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.req_i) state_d = access_ok ? MEM : RESP;
      end
      MEM: begin
        if (bus.mem_ready_i || timeout) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      rw_q        <= 1'b0;
      be_q        <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      strobe_q    <= 1'b0;
      err_q       <= 1'b0;
      other_err_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q  <= state_d;
      strobe_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.req_i) begin
            addr_q      <= bus.add_i;
            rw_q        <= bus.we_i;
            be_q        <= bus.be_i;
            wdata_q     <= bus.wdata_i;
            cnt_q       <= '0;
            other_err_q <= 1'b0;
            strobe_q    <= access_ok;
            err_q       <= !access_ok;
            if (!access_ok) rdata_q <= '0;
          end
        end
        MEM: begin
          if (bus.mem_ready_i) begin
            rdata_q <= rw_q ? '0 : bus.mem_data_i;
          end else if (timeout) begin
            other_err_q <= 1'b1;
            rdata_q     <= '0;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        RESP: begin
          err_q       <= 1'b0;
          other_err_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Grant is combinational but must stay low while reset is held.
  assign bus.gnt_o             = rst_ni && (state_q == IDLE) && bus.req_i;
  assign bus.r_valid_o         = (state_q == RESP);
  assign bus.r_err_o           = (state_q == RESP) && err_q;
  assign bus.r_other_err_o     = (state_q == RESP) && other_err_q;
  assign bus.r_rdata_o         = rdata_q;
  assign bus.mem_strobe_o      = strobe_q;
  assign bus.mem_addr_o        = addr_q;
  assign bus.mem_rw_o          = rw_q;
  assign bus.mem_byte_enable_o = be_q;
  assign bus.mem_data_o        = wdata_q;

endmodule
